// File: rtl/ii_box_sum.sv
// ii_box_sum: rectangle-sum engine reading four integral-image corners.
// Sum = D - B - C + A, where corners on row -1 or column -1 read as zero.
// Build option: define II_BOX_SUM_BRAM_OREG_EN when the buffer output
// register is enabled (read latency 2, one extra drain cycle).
module ii_box_sum #(
    parameter int unsigned IMG_W  = 160,
    parameter int unsigned IMG_H  = 120,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_x,
    input  logic [6:0]        req_y,
    input  logic [7:0]        req_w,
    input  logic [6:0]        req_h,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              sum_valid,
    output logic [DATA_W-1:0] sum_out,
    output logic              sum_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE_D = 3'd1;
    localparam logic [2:0] S_ISSUE_B = 3'd2;
    localparam logic [2:0] S_ISSUE_C = 3'd3;
    localparam logic [2:0] S_ISSUE_A = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
`ifdef II_BOX_SUM_BRAM_OREG_EN
    localparam logic [2:0] S_DRAIN2     = 3'd7;
    localparam logic [2:0] S_LAST_DRAIN = S_DRAIN2;
    localparam int unsigned RD_LAT      = 2;
`else
    localparam logic [2:0] S_LAST_DRAIN = S_DRAIN;
    localparam int unsigned RD_LAT      = 1;
`endif

    logic [2:0]        state_q, state_d;
    logic [7:0]        x0_q, x1_q;
    logic [6:0]        y0_q, y1_q;
    logic              err_q;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] sum_q;
    logic              sum_err_q;
    logic [RD_LAT-1:0] tag_v_q, tag_v_d;
    logic [RD_LAT-1:0] tag_sub_q, tag_sub_d;

    logic              accept;
    logic              req_err;
    logic              term_on;
    logic              term_sub;
    logic [ADDR_W-1:0] term_addr;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] col, input logic [6:0] row);
        return ADDR_W'(32'(row) * IMG_W + 32'(col));
    endfunction

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = (req_w == '0) || (req_h == '0) ||
                       ((32'(req_x) + 32'(req_w)) > IMG_W) ||
                       ((32'(req_y) + 32'(req_h)) > IMG_H);

    // Fixed-length walk through the four corner reads and the drain cycle(s).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_ISSUE_D;
            S_ISSUE_D: state_d = S_ISSUE_B;
            S_ISSUE_B: state_d = S_ISSUE_C;
            S_ISSUE_C: state_d = S_ISSUE_A;
            S_ISSUE_A: state_d = S_DRAIN;
`ifdef II_BOX_SUM_BRAM_OREG_EN
            S_DRAIN:   state_d = S_DRAIN2;
            S_DRAIN2:  state_d = S_DONE;
`else
            S_DRAIN:   state_d = S_DONE;
`endif
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Corner read issue: a term on row -1 / column -1 (or an error box) is skipped.
    always_comb begin
        term_on   = 1'b0;
        term_sub  = 1'b0;
        term_addr = '0;
        case (state_q)
            S_ISSUE_D: begin
                term_on   = !err_q;
                term_addr = addr_of(x1_q, y1_q);
            end
            S_ISSUE_B: begin
                term_on   = !err_q && (x0_q != '0);
                term_sub  = 1'b1;
                term_addr = addr_of(x0_q - 8'd1, y1_q);
            end
            S_ISSUE_C: begin
                term_on   = !err_q && (y0_q != '0);
                term_sub  = 1'b1;
                term_addr = addr_of(x1_q, y0_q - 7'd1);
            end
            S_ISSUE_A: begin
                term_on   = !err_q && (x0_q != '0) && (y0_q != '0);
                term_addr = addr_of(x0_q - 8'd1, y0_q - 7'd1);
            end
            default: ;
        endcase
    end

    assign rd_en   = term_on;
    assign rd_addr = term_on ? term_addr : '0;

    // Tags travel alongside the buffer latency so returning data is added or subtracted.
    always_comb begin
        tag_v_d   = RD_LAT'({tag_v_q, term_on});
        tag_sub_d = RD_LAT'({tag_sub_q, term_sub});
        acc_d     = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (tag_v_q[RD_LAT-1]) begin
            acc_d = tag_sub_q[RD_LAT-1] ? (acc_q - rd_data) : (acc_q + rd_data);
        end
    end

    // State, request capture, accumulator and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            tag_v_q   <= '0;
            tag_sub_q <= '0;
            sum_q     <= '0;
            sum_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tag_v_q   <= tag_v_d;
            tag_sub_q <= tag_sub_d;
            if (accept) begin
                x0_q  <= req_x;
                y0_q  <= req_y;
                x1_q  <= req_x + req_w - 8'd1;
                y1_q  <= req_y + req_h - 7'd1;
                err_q <= req_err;
            end
            // The final term lands in the last drain cycle, so capture acc_d there.
            if (state_q == S_LAST_DRAIN) begin
                sum_q     <= err_q ? '0 : acc_d;
                sum_err_q <= err_q;
            end
        end
    end

    assign sum_valid = (state_q == S_DONE);
    assign sum_out   = sum_q;
    assign sum_err   = sum_err_q;

endmodule

// File: tb/tb_ii_box_sum.sv
// Self-checking bench for ii_box_sum with an integral-image buffer model.
// Honours II_BOX_SUM_BRAM_OREG_EN for buffer latency and expected timing.
module tb_ii_box_sum;

`ifdef II_BOX_SUM_BRAM_OREG_EN
    localparam int RES = 7;
    localparam int PER = 8;
`else
    localparam int RES = 6;
    localparam int PER = 7;
`endif
    localparam int W = 160;
    localparam int H = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_x = '0;
    logic [6:0]  req_y = '0;
    logic [7:0]  req_w = '0;
    logic [6:0]  req_h = '0;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [19:0] rd_data;
    logic        sum_valid;
    logic [19:0] sum_out;
    logic        sum_err;

    int total = 0;
    int bad   = 0;
    int cur_mode = 0;

    typedef struct {
        int x; int y; int w; int h;
        int mode;
        int exp_sum;   // -1: take from the pixel-summing model
        int exp_err;
    } vec_t;

    ii_box_sum #(.IMG_W(160), .IMG_H(120), .ADDR_W(15), .DATA_W(20)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .sum_valid(sum_valid), .sum_out(sum_out), .sum_err(sum_err)
    );

    always #5 clk = ~clk;

    // Buffer model
    int          pix    [0:W*H-1];
    logic [19:0] ii_mem [0:W*H-1];
    logic [19:0] rd_q1 = '0;
    logic [19:0] rd_q2 = '0;

    always @(posedge clk) begin
        if (rd_en) rd_q1 <= (rd_addr < 15'd19200) ? ii_mem[rd_addr] : 20'hABCDE;
        rd_q2 <= rd_q1;
    end
`ifdef II_BOX_SUM_BRAM_OREG_EN
    assign rd_data = rd_q2;
`else
    assign rd_data = rd_q1;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic load_image(input int mode);
        int s;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y*W+x] = (mode == 1) ? 1 : (mode == 2) ? ((x + y) & 15) : int'($urandom_range(0, 15));
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                s = pix[y*W+x];
                if (x > 0) s += int'(ii_mem[y*W+x-1]);
                if (y > 0) s += int'(ii_mem[(y-1)*W+x]);
                if (x > 0 && y > 0) s -= int'(ii_mem[(y-1)*W+x-1]);
                ii_mem[y*W+x] = 20'(s);
            end
        cur_mode = mode;
    endtask

    function automatic int box_ref(input int x, input int y, input int w, input int h);
        int s = 0;
        for (int j = y; j < y + h; j++)
            for (int i = x; i < x + w; i++)
                s += pix[j*W+i];
        return s;
    endfunction

    function automatic int box_err(input int x, input int y, input int w, input int h);
        return (w == 0 || h == 0 || x + w > W || y + h > H) ? 1 : 0;
    endfunction

    task automatic do_box(input int x, input int y, input int w, input int h,
                          input int exp_sum, input int exp_err);
        int mask = 0, nz = 0, nval = 0, vcyc = -1, vsum = -1, verr = -1;
        int adr [4];
        int eadr [4];
        int emask;
        int x1 = x + w - 1, y1 = y + h - 1;
        emask = 0;
        if (exp_err == 0) begin
            emask |= 1;
            if (x != 0) emask |= 2;
            if (y != 0) emask |= 4;
            if (x != 0 && y != 0) emask |= 8;
        end
        eadr[0] = y1*W + x1;
        eadr[1] = y1*W + x - 1;
        eadr[2] = (y-1)*W + x1;
        eadr[3] = (y-1)*W + x - 1;
        for (int j = 0; j < 4; j++) adr[j] = -1;

        @(negedge clk);
        chk("ready_before", int'(req_ready), 1);
        req_valid = 1'b1;
        req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_x = 8'($urandom); req_y = 7'($urandom);
                req_w = 8'($urandom); req_h = 7'($urandom);
            end
            if (rd_en) begin
                mask |= (1 << (k - 1));
                if (k <= 4) adr[k-1] = int'(rd_addr);
            end else if (rd_addr != '0) nz++;
            if (sum_valid) begin
                nval++; vcyc = k; vsum = int'(sum_out); verr = int'(sum_err);
            end
            if (k == RES + 1) begin
                chk("sum_hold", int'(sum_out), exp_sum);
                chk("err_hold", int'(sum_err), exp_err);
                chk("ready_after", int'(req_ready), 1);
            end
        end
        chk("valid_count", nval, 1);
        chk("valid_cycle", vcyc, RES);
        chk("sum", vsum, exp_sum);
        chk("err", verr, exp_err);
        chk("rd_mask", mask, emask);
        chk("rd_addr_idle", nz, 0);
        for (int j = 0; j < 4; j++)
            if (((emask >> j) & 1) != 0) chk("rd_addr", adr[j], eadr[j]);
    endtask

    task automatic b2b_test();
        int bx [3] = '{2, 100, 0};
        int by [3] = '{3, 50, 0};
        int bw [3] = '{20, 60, 1};
        int bh [3] = '{10, 70, 1};
        int acc_c [3] = '{-1, -1, -1};
        int res_c [3] = '{-1, -1, -1};
        int res_s [3] = '{-1, -1, -1};
        int idx = 0, nres = 0;
        @(negedge clk);
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (sum_valid && nres < 3) begin
                res_c[nres] = c; res_s[nres] = int'(sum_out); nres++;
            end
            if (idx < 3) begin
                req_valid = 1'b1;
                req_x = 8'(bx[idx]); req_y = 7'(by[idx]);
                req_w = 8'(bw[idx]); req_h = 7'(bh[idx]);
                if (req_ready) begin
                    acc_c[idx] = c; idx++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_accept", acc_c[i], i*PER);
            chk("b2b_result", res_c[i], i*PER + RES);
            chk("b2b_sum", res_s[i], box_ref(bx[i], by[i], bw[i], bh[i]));
        end
    endtask

    task automatic reset_mid(input int x, input int y, input int w, input int h);
        int nv = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (sum_valid) nv++;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                chk("rst_rd_en", int'(rd_en), 0);
                chk("rst_rd_addr", int'(rd_addr), 0);
                chk("rst_sum_out", int'(sum_out), 0);
                chk("rst_sum_err", int'(sum_err), 0);
                rst = 1'b0;
                #1;
                chk("rst_ready", int'(req_ready), 1);
            end
        end
        chk("rst_no_valid", nv, 0);
    endtask

    vec_t vt[$];

    initial begin
        int x, y, w, h, e, s;
        vt.push_back('{0,   0,   160, 120, 1, 19200, 0});
        vt.push_back('{5,   7,   10,  4,   1, 40,    0});
        vt.push_back('{159, 119, 1,   1,   1, 1,     0});
        vt.push_back('{10,  20,  4,   3,   2, -1,    0});
        vt.push_back('{0,   5,   1,   1,   2, 5,     0});
        vt.push_back('{158, 0,   3,   1,   2, 0,     1});
        vt.push_back('{0,   0,   0,   5,   2, 0,     1});
        vt.push_back('{3,   3,   4,   0,   2, 0,     1});
        vt.push_back('{1,   1,   159, 119, 2, -1,    0});
        vt.push_back('{0,   119, 160, 1,   2, -1,    0});
        vt.push_back('{0,   118, 5,   3,   2, 0,     1});

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ready", int'(req_ready), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_valid", int'(sum_valid), 0);
        chk("reset_sum", int'(sum_out), 0);
        chk("reset_err", int'(sum_err), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", int'(req_ready), 1);

        foreach (vt[i]) begin
            if (vt[i].mode != cur_mode) load_image(vt[i].mode);
            s = (vt[i].exp_sum < 0) ? box_ref(vt[i].x, vt[i].y, vt[i].w, vt[i].h) : vt[i].exp_sum;
            do_box(vt[i].x, vt[i].y, vt[i].w, vt[i].h, s, vt[i].exp_err);
        end

        load_image(3);
        for (int n = 0; n < 24; n++) begin
            x = int'($urandom_range(0, 159));
            y = int'($urandom_range(0, 119));
            if ($urandom_range(0, 7) == 0) w = int'($urandom_range(0, 255));
            else w = int'($urandom_range(1, 160 - x));
            if ($urandom_range(0, 7) == 0) h = int'($urandom_range(0, 127));
            else h = int'($urandom_range(1, 120 - y));
            e = box_err(x, y, w, h);
            do_box(x, y, w, h, (e != 0) ? 0 : box_ref(x, y, w, h), e);
        end

        b2b_test();

        do_box(0, 0, 160, 120, box_ref(0, 0, 160, 120), 0);
        reset_mid(7, 9, 30, 20);
        do_box(7, 9, 30, 20, box_ref(7, 9, 30, 20), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
